// File: rtl/strip_window_buffer_if.sv
// Avalon read-data beat bus feeding the strip window buffer.
// The read master drives it, the buffer consumes it.
interface strip_window_buffer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] master_readdata;
    logic                  master_readdatavalid;

    modport master (
        output master_readdata,
        output master_readdatavalid
    );

    modport slave (
        input master_readdata,
        input master_readdatavalid
    );
endinterface

// File: rtl/strip_window_buffer.sv
// 3x8 pixel strip with a staging row.
// Serves registered 3x3 windows to the cartoon filter.
module strip_window_buffer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      n_rst,
    strip_window_buffer_if.slave      rd,
    input  logic                      shift_enable24,
    input  logic                      load_read_buffer,
    input  logic                      shift_enable8,
    input  logic                      pixel_enable,
    output logic                      done_read24,
    output logic                      done_load_read_buffer,
    output logic                      done_shift8,
    output logic [9*DATA_WIDTH-1:0]   window_out,
    output logic                      window_valid
);

    logic [DATA_WIDTH-1:0] strip   [3][8];
    logic [DATA_WIDTH-1:0] staging [8];
    logic [4:0]            fill_cnt;
    logic [3:0]            stage_cnt;
    logic [2:0]            col_ptr;

    logic       fill_beat;
    logic       fill_last;
    logic       do_shift;
    logic       stage_beat;
    logic [2:0] stage_idx;

    assign fill_beat = shift_enable24 && rd.master_readdatavalid;
    assign fill_last = (fill_cnt == 5'd23);
    assign do_shift  = shift_enable8 && (stage_cnt == 4'd8);

    // A shift frees the staging row, so a beat in that cycle lands in slot 0.
    assign stage_beat = load_read_buffer && rd.master_readdatavalid &&
                        !shift_enable24 &&
                        ((stage_cnt != 4'd8) || do_shift);
    assign stage_idx  = do_shift ? 3'd0 : stage_cnt[2:0];

    assign done_load_read_buffer = (stage_cnt == 4'd8);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 8; c++) begin
                    strip[r][c] <= '0;
                end
            end
            for (int c = 0; c < 8; c++) begin
                staging[c] <= '0;
            end
            fill_cnt     <= '0;
            stage_cnt    <= '0;
            col_ptr      <= '0;
            done_read24  <= 1'b0;
            done_shift8  <= 1'b0;
            window_out   <= '0;
            window_valid <= 1'b0;
        end else begin
            done_read24  <= fill_beat && fill_last;
            done_shift8  <= do_shift;
            window_valid <= pixel_enable;

            if (pixel_enable) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        window_out[(3*r+c)*DATA_WIDTH +: DATA_WIDTH] <=
                            strip[r][col_ptr + 3'(c)];
                    end
                end
                col_ptr <= (col_ptr == 3'd5) ? 3'd0 : col_ptr + 3'd1;
            end

            // Later assignments intentionally override the col_ptr advance.
            if (do_shift) begin
                for (int c = 0; c < 8; c++) begin
                    strip[0][c] <= strip[1][c];
                    strip[1][c] <= strip[2][c];
                    strip[2][c] <= staging[c];
                end
                stage_cnt <= '0;
                col_ptr   <= '0;
            end

            if (fill_beat) begin
                strip[fill_cnt[4:3]][fill_cnt[2:0]] <= rd.master_readdata;
                if (fill_last) begin
                    fill_cnt <= '0;
                    col_ptr  <= '0;
                end else begin
                    fill_cnt <= fill_cnt + 5'd1;
                end
            end

            if (stage_beat) begin
                staging[stage_idx] <= rd.master_readdata;
                stage_cnt <= do_shift ? 4'd1 : stage_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_strip_window_buffer.sv
// Scoreboard bench for strip_window_buffer.
// Random and directed stimulus against a queue-based strip model.
module tb_strip_window_buffer;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    strip_window_buffer_if #(.DATA_WIDTH(DW)) rd ();

    logic se24 = 1'b0;
    logic lrb = 1'b0;
    logic se8 = 1'b0;
    logic pe = 1'b0;
    logic done_read24;
    logic done_load_read_buffer;
    logic done_shift8;
    logic [9*DW-1:0] window_out;
    logic window_valid;

    strip_window_buffer #(.DATA_WIDTH(DW)) dut (
        .clk                   (clk),
        .n_rst                 (n_rst),
        .rd                    (rd),
        .shift_enable24        (se24),
        .load_read_buffer      (lrb),
        .shift_enable8         (se8),
        .pixel_enable          (pe),
        .done_read24           (done_read24),
        .done_load_read_buffer (done_load_read_buffer),
        .done_shift8           (done_shift8),
        .window_out            (window_out),
        .window_valid          (window_valid)
    );

    int checks = 0;
    int errors = 0;
    int edges = 0;

    typedef struct {
        int              e;
        logic [9*DW-1:0] w;
    } win_t;

    win_t wq[$];
    int   rd24q[$];
    int   sh8q[$];

    logic [9*DW-1:0] last_win;
    logic [DW-1:0]   m_strip [3][8];
    logic [DW-1:0]   m_stage[$];
    int              m_fill;
    int              m_col;

    function automatic logic [9*DW-1:0] model_win();
        logic [9*DW-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(3*r+c)*DW +: DW] = m_strip[r][m_col+c];
        return w;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 8; c++)
                m_strip[r][c] = '0;
        m_stage.delete();
        m_fill = 0;
        m_col = 0;
        last_win = '0;
        wq.delete();
        rd24q.delete();
        sh8q.delete();
    endtask

    task automatic step(input logic a, input logic b, input logic c,
                        input logic p, input logic v,
                        input logic [DW-1:0] d);
        win_t t;
        se24 = a;
        lrb = b;
        se8 = c;
        pe = p;
        rd.master_readdatavalid = v;
        rd.master_readdata = d;
        @(posedge clk);
        edges++;
        if (p) begin
            t.e = edges;
            t.w = model_win();
            wq.push_back(t);
            last_win = t.w;
            m_col = (m_col + 1) % 6;
        end
        if (a && v) begin
            m_strip[m_fill/8][m_fill%8] = d;
            m_fill++;
            if (m_fill == 24) begin
                m_fill = 0;
                m_col = 0;
                rd24q.push_back(edges);
            end
        end
        if (c && m_stage.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                m_strip[0][i] = m_strip[1][i];
                m_strip[1][i] = m_strip[2][i];
                m_strip[2][i] = m_stage[i];
            end
            m_stage.delete();
            m_col = 0;
            sh8q.push_back(edges);
        end
        if (b && v && !a && m_stage.size() < 8)
            m_stage.push_back(d);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (window_out !== '0 || window_valid !== 1'b0 ||
            done_read24 !== 1'b0 || done_shift8 !== 1'b0 ||
            done_load_read_buffer !== 1'b0) begin
            errors++;
            $display("FAIL %s: got win=%h v=%b r24=%b s8=%b dlrb=%b, need all 0",
                     tag, window_out, window_valid, done_read24,
                     done_shift8, done_load_read_buffer);
        end
    endtask

    task automatic mid_reset(input string tag);
        #2 n_rst = 1'b0;
        #1 check_zero(tag);
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    always @(negedge clk) begin
        bit ev;
        bit er;
        bit es;
        logic [9*DW-1:0] w;
        if (n_rst) begin
            ev = (wq.size() > 0) && (wq[0].e == edges);
            if (ev || window_valid) begin
                checks++;
                if (window_valid !== ev) begin
                    errors++;
                    $display("FAIL window_valid @%0d: got %b need %b",
                             edges, window_valid, ev);
                end
            end
            if (ev) begin
                w = wq.pop_front().w;
                checks++;
                if (window_out !== w) begin
                    errors++;
                    $display("FAIL window @%0d: got %h need %h",
                             edges, window_out, w);
                end
            end
            checks++;
            if (window_out !== last_win) begin
                errors++;
                $display("FAIL window_hold @%0d: got %h need %h",
                         edges, window_out, last_win);
            end
            er = (rd24q.size() > 0) && (rd24q[0] == edges);
            if (er) void'(rd24q.pop_front());
            if (er || done_read24) begin
                checks++;
                if (done_read24 !== er) begin
                    errors++;
                    $display("FAIL done_read24 @%0d: got %b need %b",
                             edges, done_read24, er);
                end
            end
            es = (sh8q.size() > 0) && (sh8q[0] == edges);
            if (es) void'(sh8q.pop_front());
            if (es || done_shift8) begin
                checks++;
                if (done_shift8 !== es) begin
                    errors++;
                    $display("FAIL done_shift8 @%0d: got %b need %b",
                             edges, done_shift8, es);
                end
            end
            checks++;
            if (done_load_read_buffer !== (m_stage.size() == 8)) begin
                errors++;
                $display("FAIL done_load @%0d: got %b need %b",
                         edges, done_load_read_buffer, m_stage.size() == 8);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic a, b, c, p, v;
        rd.master_readdatavalid = 1'b0;
        rd.master_readdata = '0;
        model_reset();
        #3 check_zero("reset_init");
        @(negedge clk);
        n_rst = 1'b1;
        idle(2);

        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100 + 32'(i));
        mid_reset("reset_mid_fill");
        idle(1);

        for (int i = 0; i < 24; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'(i));
        idle(2);
        for (int i = 0; i < 7; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        idle(2);

        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20 + 32'(i));
        idle(1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        idle(2);

        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h30 + 32'(i));
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 5; i < 8; i++)
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h30 + 32'(i));
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        idle(2);

        for (int n = 0; n < 1500; n++) begin
            if (n == 700) mid_reset("reset_random");
            a = ($urandom % 4) == 0;
            b = ($urandom % 2) == 0;
            c = !a && (($urandom % 4) == 0);
            p = ($urandom % 3) == 0;
            v = ($urandom % 4) != 0;
            step(a, b, c, p, v, DW'($urandom));
        end
        idle(3);

        checks++;
        if (wq.size() != 0 || rd24q.size() != 0 || sh8q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d/%0d pending, need 0/0/0",
                     wq.size(), rd24q.size(), sh8q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
